// File: rtl/apx_mul_seq.sv
// Iterative shift-add approximate unsigned multiplier, W-bit operands, 2W-bit product.
// Define APX_MUL_BIAS_COMP_EN to add +2^(K-1) bias compensation to truncated results.
module apx_mul_seq #(
    parameter  int W  = 8,
    localparam int KW = $clog2(W + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
    input  logic [KW-1:0]   in_k,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_p,
    output logic            busy
);

    localparam int PW = 2 * W;
    localparam int CW = $clog2(W);
    localparam logic [KW-1:0] K_MAX    = KW'(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [KW-1:0]   k_reg;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic [KW-1:0]   k_clamp;
    logic [PW-1:0]   mask;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   sum;
    logic [PW-1:0]   bias;
    logic [PW-1:0]   final_p;

    // Column mask keeps bits at or above K; K is already clamped to W.
    always_comb begin
        k_clamp = (in_k > K_MAX) ? K_MAX : in_k;
        mask    = {PW{1'b1}} << k_reg;
        pp      = '0;
        if (b_reg[cnt]) begin
            pp = ({{W{1'b0}}, a_reg} << cnt) & mask;
        end
        sum  = acc + pp;
        bias = '0;
`ifdef APX_MUL_BIAS_COMP_EN
        if (k_reg != '0 && a_reg != '0 && b_reg != '0) begin
            bias = PW'(1) << (k_reg - 1'b1);
        end
`endif
        final_p = sum + bias;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_p     <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            k_reg     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        k_reg    <= k_clamp;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= sum;
                    if (cnt == CNT_LAST) begin
                        out_p     <= final_p;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apx_mul_seq.sv
// Bench for apx_mul_seq: directed table, corner sequences, randomised W=8/W=12 scoreboard.
module tb_apx_mul_seq;

`ifdef APX_MUL_BIAS_COMP_EN
    localparam bit BIAS = 1'b1;
`else
    localparam bit BIAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        sel;
    logic [11:0] in_a;
    logic [11:0] in_b;
    logic [3:0]  in_k;

    logic        iv8, ir8, ov8, busy8;
    logic [15:0] p8;
    logic        iv12, ir12, ov12, busy12;
    logic [23:0] p12;

    logic        ir_m, ov_m, busy_m;
    logic [23:0] p_m;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    assign iv8    = in_valid & ~sel;
    assign iv12   = in_valid & sel;
    assign ir_m   = sel ? ir12 : ir8;
    assign ov_m   = sel ? ov12 : ov8;
    assign busy_m = sel ? busy12 : busy8;
    assign p_m    = sel ? p12 : {8'h00, p8};

    apx_mul_seq #(.W(8)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_k(in_k),
        .out_valid(ov8), .out_ready(out_ready),
        .out_p(p8), .busy(busy8)
    );

    apx_mul_seq #(.W(12)) u12 (
        .clk(clk), .rst(rst),
        .in_valid(iv12), .in_ready(ir12),
        .in_a(in_a), .in_b(in_b), .in_k(in_k),
        .out_valid(ov12), .out_ready(out_ready),
        .out_p(p12), .busy(busy12)
    );

    typedef struct {
        string       nm;
        logic [11:0] a;
        logic [11:0] b;
        logic [3:0]  k;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [23:0] act,
                       input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out", nm);
    endtask

    function automatic logic [23:0] model(input logic [11:0] a,
                                          input logic [11:0] b,
                                          input int k, input int w);
        int          kc;
        logic [23:0] m;
        logic [23:0] s;
        kc = (k > w) ? w : k;
        m  = ~((24'd1 << kc) - 24'd1);
        s  = '0;
        for (int i = 0; i < w; i++) begin
            if (b[i]) s += ({12'h000, a} << i) & m;
        end
        if (BIAS && kc >= 1 && a != 0 && b != 0) s += 24'd1 << (kc - 1);
        return s;
    endfunction

    task automatic do_op(input string nm, input logic [11:0] a,
                         input logic [11:0] b, input logic [3:0] k,
                         input logic [23:0] exp, input int pct);
        int g;
        bit done;
        exp_q.push_back(exp);
        in_a = a;
        in_b = b;
        in_k = k;
        in_valid = 1'b1;
        g = 0;
        while (!ir_m && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!ir_m) begin
            timeout({nm, "_accept"});
            in_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(99) < pct);
            if (ov_m && out_ready) begin
                chk(nm, p_m, exp_q.pop_front());
                done = 1'b1;
            end
        end
        if (!done) begin
            timeout({nm, "_result"});
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"exact_ff",  12'd255, 12'd255, 4'd0,  24'd65025};
        tbl[1] = '{"k4_ff",     12'd255, 12'd255, 4'd4,
                   BIAS ? 24'd64984 : 24'd64976};
        tbl[2] = '{"k2_3x5",    12'd3,   12'd5,   4'd2,
                   BIAS ? 24'd14 : 24'd12};
        tbl[3] = '{"kclamp",    12'd3,   12'd5,   4'd15,
                   BIAS ? 24'd128 : 24'd0};
        tbl[4] = '{"a_zero",    12'd0,   12'd200, 4'd3,  24'd0};
        tbl[5] = '{"exact_17x9", 12'd17, 12'd9,   4'd0,  24'd153};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sel = 1'b0;
        in_a = '0;
        in_b = '0;
        in_k = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 24'(ir8), 24'd1);
        chk("rst_out_valid", 24'(ov8), 24'd0);
        chk("rst_out_p", 24'(p8), 24'd0);
        chk("rst_busy", 24'(busy8), 24'd0);
        chk("rst_p12", p12, 24'd0);
        rst = 1'b0;
        @(negedge clk);

        // Latency: out_valid only in cycle W+1, in_ready back in cycle W+2.
        in_a = 12'd255;
        in_b = 12'd255;
        in_k = 4'd0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_q.push_back(24'd65025);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("lat_ov_c%0d", c), 24'(ov8), (c == 9) ? 24'd1 : 24'd0);
            if (c == 9) chk("lat_p", p_m, exp_q.pop_front());
        end
        @(negedge clk);
        chk("lat_ir_c10", 24'(ir8), 24'd1);
        chk("lat_ov_c10", 24'(ov8), 24'd0);
        out_ready = 1'b0;

        foreach (tbl[i]) begin
            do_op(tbl[i].nm, tbl[i].a, tbl[i].b, tbl[i].k, tbl[i].exp, 100);
        end

        // Back-pressure in DONE with a competing request.
        in_a = 12'd0;
        in_b = 12'd200;
        in_k = 4'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_q.push_back(24'd0);
        repeat (9) @(negedge clk);
        chk("hold_p", p_m, exp_q.pop_front());
        in_a = 12'd7;
        in_b = 12'd7;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold_ov%0d", c), 24'(ov8), 24'd1);
            chk($sformatf("hold_p%0d", c), p_m, 24'd0);
            chk($sformatf("hold_ir%0d", c), 24'(ir8), 24'd0);
            chk($sformatf("hold_busy%0d", c), 24'(busy8), 24'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_ov", 24'(ov8), 24'd0);
        chk("release_ir", 24'(ir8), 24'd1);
        chk("release_busy", 24'(busy8), 24'd0);
        chk("release_p_kept", p_m, 24'd0);

        // Reset mid-BUSY discards the operation.
        do_op("pre_rst", 12'd255, 12'd3, 4'd0, 24'd765, 100);
        in_a = 12'd17;
        in_b = 12'd9;
        in_k = 4'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ir", 24'(ir8), 24'd1);
        chk("midrst_ov", 24'(ov8), 24'd0);
        chk("midrst_p", p_m, 24'd0);
        chk("midrst_busy", 24'(busy8), 24'd0);
        do_op("post_rst", 12'd17, 12'd9, 4'd0, 24'd153, 100);

        for (int n = 0; n < 1000; n++) begin
            logic [11:0] a;
            logic [11:0] b;
            logic [3:0]  k;
            int          w;
            sel = (n >= 500);
            w = sel ? 12 : 8;
            a = 12'($urandom);
            b = 12'($urandom);
            if ($urandom_range(15) == 0) a = '0;
            if ($urandom_range(15) == 0) b = '0;
            if (!sel) begin
                a[11:8] = '0;
                b[11:8] = '0;
            end
            k = 4'($urandom_range(15));
            do_op($sformatf("rnd_w%0d_%0d", w, n), a, b, k,
                  model(a, b, int'(k), w), $urandom_range(100, 30));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
